// File: rtl/cpu_pkg.sv
// Shared opcode, control-word and hazard FSM definitions for the 5-stage MIPS core.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam int REGDST_LSB   = 0;
  localparam int MEMREAD_BIT  = 10;
  localparam int MEMTOREG_BIT = 13;
  localparam int REGWRITE_BIT = 14;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr takes priority over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-operand hazard detection with stall/flush control,
// state tracking, saturating counters and a sticky stall watchdog.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instr_id_i,
  input  logic [31:0]      Signal_ex_i,
  input  logic [31:0]      Instr_ex_i,
  input  logic             RegWrite_mem_i,
  input  logic             MemRead_mem_i,
  input  logic [4:0]       WriteReg_mem_i,
  input  logic             BranchTaken_id_i,
  output logic             stall_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             hazard_err_o
);
  localparam int RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);

  logic [5:0] opcode;
  logic [4:0] rs, rt, dst_ex;
  logic       uses_rs, uses_rt, is_br;
  logic       memread_ex, regwrite_ex;
  logic       load_use, br_ex, br_mem, haz;
  logic [RUN_W-1:0] run_cnt;
  hz_state_e  state_reg;
  logic       err_reg;

  assign opcode = Instr_id_i[31:26];
  assign rs     = Instr_id_i[25:21];
  assign rt     = Instr_id_i[20:16];

  assign uses_rs = (opcode != OP_J) && (opcode != OP_JAL);
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                   (opcode == OP_BNE) || (opcode == OP_SW);
  assign is_br   = (opcode == OP_BEQ) || (opcode == OP_BNE);

  assign memread_ex  = Signal_ex_i[MEMREAD_BIT];
  assign regwrite_ex = Signal_ex_i[REGWRITE_BIT];

  // RegDst = 11 is not a real encoding; treat it as writing $0 (no hazard)
  always_comb begin
    dst_ex = 5'd0;
    case (Signal_ex_i[REGDST_LSB +: 2])
      2'b00:   dst_ex = Instr_ex_i[20:16];
      2'b01:   dst_ex = Instr_ex_i[15:11];
      2'b10:   dst_ex = 5'd31;
      default: dst_ex = 5'd0;
    endcase
  end

  assign load_use = memread_ex && (dst_ex != 5'd0) &&
                    ((uses_rs && (dst_ex == rs)) || (uses_rt && (dst_ex == rt)));
  assign br_ex    = is_br && regwrite_ex && (dst_ex != 5'd0) &&
                    ((dst_ex == rs) || (dst_ex == rt));
  assign br_mem   = is_br && MemRead_mem_i && RegWrite_mem_i && (WriteReg_mem_i != 5'd0) &&
                    ((WriteReg_mem_i == rs) || (WriteReg_mem_i == rt));
  assign haz      = load_use || br_ex || br_mem;

  // Holding the pipeline frozen while reset is asserted
  assign stall_o     = !rst_n || haz;
  assign PCWrite_o   = rst_n && !haz;
  assign IFIDWrite_o = rst_n && !haz;
  assign IFIDFlush_o = rst_n && BranchTaken_id_i && !haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= ST_RUN;
    else if (haz)
      state_reg <= ST_STALL;
    else if (IFIDFlush_o)
      state_reg <= ST_FLUSH;
    else
      state_reg <= ST_RUN;
  end
  assign state_o = state_reg;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall_o), .clr(1'b0), .cnt(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(IFIDFlush_o), .clr(1'b0), .cnt(flush_cnt_o)
  );
  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk(clk), .rst_n(rst_n), .inc(haz), .clr(!haz), .cnt(run_cnt)
  );

  // Flag on the same edge the run counter reaches MAX_STALL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_reg <= 1'b0;
    else if (haz && (run_cnt >= RUN_LAST))
      err_reg <= 1'b1;
  end
  assign hazard_err_o = err_reg;

  logic unused_bits;
  assign unused_bits = ^{Signal_ex_i[31:15], Signal_ex_i[13:11], Signal_ex_i[9:2],
                         Instr_ex_i[31:21], Instr_ex_i[10:0], Instr_id_i[15:0]};
endmodule

// File: tb/tb_hazard_unit.sv
// Directed checks of hazard_unit: load-use, branch hazards, flush, watchdog, reset.
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instr_id_i, Signal_ex_i, Instr_ex_i;
  logic        RegWrite_mem_i, MemRead_mem_i, BranchTaken_id_i;
  logic [4:0]  WriteReg_mem_i;
  logic        stall_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, hazard_err_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MAX_STALL(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Instr_id_i(Instr_id_i), .Signal_ex_i(Signal_ex_i), .Instr_ex_i(Instr_ex_i),
    .RegWrite_mem_i(RegWrite_mem_i), .MemRead_mem_i(MemRead_mem_i),
    .WriteReg_mem_i(WriteReg_mem_i), .BranchTaken_id_i(BranchTaken_id_i),
    .stall_o(stall_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
    .IFIDFlush_o(IFIDFlush_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .hazard_err_o(hazard_err_o)
  );

  localparam logic [31:0] SIG_LW   = 32'h0000_4400; // MemRead, RegWrite, RegDst=rt
  localparam logic [31:0] SIG_RRD  = 32'h0000_4001; // RegWrite, RegDst=rd
  localparam logic [31:0] SIG_R31  = 32'h0000_4002; // RegWrite, RegDst=31

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
    return {op, s, t, 16'h0004};
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Instr_id_i = 32'd0; Signal_ex_i = 32'd0; Instr_ex_i = 32'd0;
    RegWrite_mem_i = 1'b0; MemRead_mem_i = 1'b0; WriteReg_mem_i = 5'd0;
    BranchTaken_id_i = 1'b0;
  endtask

  task automatic gap();
    idle();
    tick();
  endtask

  task automatic load_use();
    Signal_ex_i = SIG_LW;
    Instr_ex_i  = itype(6'h23, 5'd1, 5'd8);   // lw $8,0($1)
    Instr_id_i  = rtype(5'd8, 5'd2, 5'd9);    // add $9,$8,$2
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst_stall", stall_o, 1);
    chk("rst_pcwrite", PCWrite_o, 0);
    chk("rst_ifidwrite", IFIDWrite_o, 0);
    chk("rst_flush", IFIDFlush_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_flush_cnt", flush_cnt_o, 0);
    chk("rst_err", hazard_err_o, 0);
    #1 rst_n = 1'b1;
    tick();

    // load-use
    load_use(); #1;
    chk("lu_stall", stall_o, 1);
    chk("lu_pcwrite", PCWrite_o, 0);
    chk("lu_ifidwrite", IFIDWrite_o, 0);
    tick(); exp_stall++;
    idle(); #1;
    chk("lu_release", stall_o, 0);
    chk("lu_pcwrite_back", PCWrite_o, 1);
    chk("lu_state", state_o, 1);
    chk("lu_stall_cnt", stall_cnt_o, exp_stall);
    tick();
    chk("lu_state_run", state_o, 0);

    // $0 destination never hazards
    Signal_ex_i = SIG_LW;
    Instr_ex_i  = itype(6'h23, 5'd1, 5'd0);
    Instr_id_i  = rtype(5'd0, 5'd0, 5'd9); #1;
    chk("zero_reg", stall_o, 0);
    tick();

    // JAL does not read rs even if its field matches
    load_use();
    Instr_id_i = itype(6'h03, 5'd8, 5'd8); #1;
    chk("jal_no_rs", stall_o, 0);
    tick();

    // SW reads rt
    load_use();
    Instr_id_i = itype(6'h2B, 5'd1, 5'd8); #1;
    chk("sw_rt", stall_o, 1);
    tick(); exp_stall++;
    gap();

    // non-load ALU producer does not stall a non-branch consumer
    Signal_ex_i = SIG_RRD;
    Instr_ex_i  = rtype(5'd1, 5'd2, 5'd9);
    Instr_id_i  = rtype(5'd9, 5'd2, 5'd10); #1;
    chk("alu_no_stall", stall_o, 0);
    Instr_id_i  = itype(6'h04, 5'd9, 5'd3); #1;
    chk("br_ex_rd", stall_o, 1);
    tick(); exp_stall++;
    gap();

    // RegDst=10 targets $31
    Signal_ex_i = SIG_R31;
    Instr_ex_i  = itype(6'h03, 5'd0, 5'd0);
    Instr_id_i  = itype(6'h05, 5'd31, 5'd0); #1;
    chk("br_ex_r31", stall_o, 1);
    tick(); exp_stall++;
    gap();

    // branch behind load: EX term, then MEM term
    Signal_ex_i = SIG_LW;
    Instr_ex_i  = itype(6'h23, 5'd1, 5'd8);
    Instr_id_i  = itype(6'h04, 5'd8, 5'd3); #1;
    chk("bl_cyc1", stall_o, 1);
    tick(); exp_stall++;
    Signal_ex_i = 32'd0; Instr_ex_i = 32'd0;
    RegWrite_mem_i = 1'b1; MemRead_mem_i = 1'b1; WriteReg_mem_i = 5'd8; #1;
    chk("bl_cyc2", stall_o, 1);
    tick(); exp_stall++;
    RegWrite_mem_i = 1'b0; MemRead_mem_i = 1'b0; WriteReg_mem_i = 5'd0; #1;
    chk("bl_cyc3", stall_o, 0);
    tick();
    chk("bl_stall_cnt", stall_cnt_o, exp_stall);
    chk("bl_err_clear", hazard_err_o, 0);

    // taken branch without and with a hazard
    idle(); BranchTaken_id_i = 1'b1; #1;
    chk("tb_flush", IFIDFlush_o, 1);
    chk("tb_nostall", stall_o, 0);
    tick(); exp_flush++;
    idle(); #1;
    chk("tb_state", state_o, 2);
    chk("tb_flush_cnt", flush_cnt_o, exp_flush);
    load_use(); BranchTaken_id_i = 1'b1; #1;
    chk("tbh_flush", IFIDFlush_o, 0);
    chk("tbh_stall", stall_o, 1);
    tick(); exp_stall++;
    chk("tbh_state", state_o, 1);
    chk("tbh_flush_cnt", flush_cnt_o, exp_flush);
    gap();

    // watchdog: 4 consecutive stall cycles
    load_use();
    tick(); tick(); tick();
    chk("wd_after3", hazard_err_o, 0);
    tick(); exp_stall += 4;
    chk("wd_after4", hazard_err_o, 1);
    idle(); tick();
    chk("wd_sticky", hazard_err_o, 1);
    chk("wd_stall_cnt", stall_cnt_o, exp_stall);

    // reset in the middle of a stall
    load_use();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_stall", stall_o, 1);
    chk("mr_pcwrite", PCWrite_o, 0);
    chk("mr_ifidwrite", IFIDWrite_o, 0);
    chk("mr_stall_cnt", stall_cnt_o, 0);
    chk("mr_flush_cnt", flush_cnt_o, 0);
    chk("mr_err", hazard_err_o, 0);
    chk("mr_state", state_o, 0);
    rst_n = 1'b1;
    tick();
    chk("mr_restart_cnt", stall_cnt_o, 1);
    chk("mr_restart_state", state_o, 1);
    chk("mr_restart_err", hazard_err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
